// File: rtl/nt_sched_pkg.sv
// Shared types and constants for the Nt-node evaluation scheduler.
package nt_sched_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } sched_state_e;

  localparam int NREQ_DEF  = 4;
  localparam int DEPTH_DEF = 3;
  localparam int DW_DEF    = 1;

  // Width of a counter that must hold values 0..depth
  function automatic int cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/nt_subckt_eval_sched_if.sv
// Bundle between the requesters/subcircuit side (master) and the scheduler (slave).
interface nt_subckt_eval_sched_if
  import nt_sched_pkg::*;
#(
  parameter int NREQ = NREQ_DEF,
  parameter int DW   = DW_DEF
);
  localparam int IW = $clog2(NREQ);

  logic [NREQ-1:0]    req;
  logic [NREQ*DW-1:0] op_a;
  logic [NREQ*DW-1:0] op_b;
  logic [NREQ*DW-1:0] op_c;
  logic [NREQ-1:0]    grant;
  logic [DW-1:0]      dp_a;
  logic [DW-1:0]      dp_b;
  logic [DW-1:0]      dp_c;
  logic               dp_en;
  logic [DW-1:0]      dp_q;
  logic               resp_valid;
  logic               resp_ready;
  logic [IW-1:0]      resp_id;
  logic [DW-1:0]      resp_data;
  logic               busy;

  modport master (
    output req, op_a, op_b, op_c, dp_q, resp_ready,
    input  grant, dp_a, dp_b, dp_c, dp_en, resp_valid, resp_id, resp_data, busy
  );

  modport slave (
    input  req, op_a, op_b, op_c, dp_q, resp_ready,
    output grant, dp_a, dp_b, dp_c, dp_en, resp_valid, resp_id, resp_data, busy
  );

endinterface

// File: rtl/nt_rr_arbiter.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping.
module nt_rr_arbiter #(
  parameter  int NREQ = 4,
  localparam int IW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic [NREQ-1:0] gnt,
  output logic [IW-1:0]   idx,
  output logic            any
);
  localparam int SW = IW + 1;

  logic [SW-1:0]   w_sum;
  logic [IW-1:0]   w_pos;
  logic [IW-1:0]   w_idx;
  logic            w_found;
  logic [NREQ-1:0] w_gnt;

  // Scan from ptr upward modulo NREQ and keep the first requester found
  always_comb begin
    w_sum   = '0;
    w_pos   = '0;
    w_idx   = '0;
    w_found = 1'b0;
    w_gnt   = '0;
    for (int i = 0; i < NREQ; i++) begin
      w_sum = {1'b0, ptr} + SW'(i);
      if (w_sum >= SW'(NREQ)) begin
        w_sum = w_sum - SW'(NREQ);
      end else begin
        w_sum = w_sum;
      end
      w_pos = w_sum[IW-1:0];
      if (!w_found && req[w_pos]) begin
        w_found = 1'b1;
        w_idx   = w_pos;
      end else begin
        w_found = w_found;
      end
    end
    if (w_found) begin
      w_gnt[w_idx] = 1'b1;
    end else begin
      w_gnt = '0;
    end
  end

  assign gnt = w_gnt;
  assign idx = w_idx;
  assign any = w_found;

endmodule

// File: rtl/nt_subckt_eval_sched.sv
// Shares one fixed-latency evaluation subcircuit among NREQ requesters:
// round-robin pick, one-cycle operand issue, wait DEPTH cycles, return result.
module nt_subckt_eval_sched
  import nt_sched_pkg::*;
#(
  parameter int NREQ  = NREQ_DEF,
  parameter int DEPTH = DEPTH_DEF,
  parameter int DW    = DW_DEF
) (
  input  logic                  I1470_clk,
  input  logic                  I1477_rst,
  nt_subckt_eval_sched_if.slave bus
);
  localparam int IW = $clog2(NREQ);
  localparam int CW = cnt_width(DEPTH);

  sched_state_e    r_state;
  sched_state_e    w_state_nxt;
  logic [IW-1:0]   r_ptr;
  logic [IW-1:0]   r_idx;
  logic [IW-1:0]   r_resp_id;
  logic [IW-1:0]   w_idx;
  logic [IW-1:0]   w_ptr_nxt;
  logic [NREQ-1:0] r_gnt;
  logic [NREQ-1:0] w_gnt;
  logic            w_any;
  logic [CW-1:0]   r_cnt;
  logic [DW-1:0]   r_dp_a;
  logic [DW-1:0]   r_dp_b;
  logic [DW-1:0]   r_dp_c;
  logic [DW-1:0]   r_resp_data;
  logic [DW-1:0]   w_op_a;
  logic [DW-1:0]   w_op_b;
  logic [DW-1:0]   w_op_c;

  nt_rr_arbiter #(.NREQ(NREQ)) u_arb (
    .req (bus.req),
    .ptr (r_ptr),
    .gnt (w_gnt),
    .idx (w_idx),
    .any (w_any)
  );

  // Operand slices belonging to the registered winner
  always_comb begin
    w_op_a = bus.op_a[int'(r_idx)*DW +: DW];
    w_op_b = bus.op_b[int'(r_idx)*DW +: DW];
    w_op_c = bus.op_c[int'(r_idx)*DW +: DW];
  end

  // Pointer advances to the slot just after the served requester
  always_comb begin
    if (r_idx == IW'(NREQ - 1)) begin
      w_ptr_nxt = '0;
    end else begin
      w_ptr_nxt = r_idx + IW'(1);
    end
  end

  // FSM state register
  always_ff @(posedge I1470_clk or negedge I1477_rst) begin
    if (!I1477_rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next-state decode
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (w_any) begin
          w_state_nxt = ISSUE;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      ISSUE: begin
        w_state_nxt = WAIT;
      end
      WAIT: begin
        if (r_cnt == '0) begin
          w_state_nxt = RESP;
        end else begin
          w_state_nxt = WAIT;
        end
      end
      RESP: begin
        if (bus.resp_ready) begin
          w_state_nxt = IDLE;
        end else begin
          w_state_nxt = RESP;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // Winner, operand hold, wait counter, result capture and fairness pointer
  always_ff @(posedge I1470_clk or negedge I1477_rst) begin
    if (!I1477_rst) begin
      r_ptr       <= '0;
      r_idx       <= '0;
      r_gnt       <= '0;
      r_cnt       <= '0;
      r_dp_a      <= '0;
      r_dp_b      <= '0;
      r_dp_c      <= '0;
      r_resp_id   <= '0;
      r_resp_data <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_any) begin
            r_idx <= w_idx;
            r_gnt <= w_gnt;
          end
        end
        ISSUE: begin
          r_dp_a <= w_op_a;
          r_dp_b <= w_op_b;
          r_dp_c <= w_op_c;
          r_cnt  <= CW'(DEPTH - 1);
        end
        WAIT: begin
          if (r_cnt == '0) begin
            r_resp_data <= bus.dp_q;
            r_resp_id   <= r_idx;
          end else begin
            r_cnt <= r_cnt - CW'(1);
          end
        end
        RESP: begin
          if (bus.resp_ready) begin
            r_ptr <= w_ptr_nxt;
          end
        end
        default: begin
          r_cnt <= '0;
        end
      endcase
    end
  end

  // Outputs are decoded from registered state; operands pass through during ISSUE
  assign bus.grant      = (r_state == ISSUE) ? r_gnt : '0;
  assign bus.dp_en      = (r_state == ISSUE);
  assign bus.dp_a       = (r_state == ISSUE) ? w_op_a : r_dp_a;
  assign bus.dp_b       = (r_state == ISSUE) ? w_op_b : r_dp_b;
  assign bus.dp_c       = (r_state == ISSUE) ? w_op_c : r_dp_c;
  assign bus.resp_valid = (r_state == RESP);
  assign bus.resp_id    = r_resp_id;
  assign bus.resp_data  = r_resp_data;
  assign bus.busy       = (r_state != IDLE);

endmodule

// File: tb/tb_nt_subckt_eval_sched.sv
// Scoreboard bench: three schedulers (DEPTH 3, 1, 15) sharing stimulus signals,
// each with an AND pipeline model of the shared subcircuit.
module tb_nt_subckt_eval_sched;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;
  int n_wait;

  logic [3:0]  req_s [3];
  logic [3:0]  op_a_s, op_b_s, op_c_s;
  logic        rdy_s;
  logic [15:0] pipe [3];

  logic [3:0] grant_w [3];
  logic       en_w [3], dpa_w [3], dpb_w [3], dpc_w [3];
  logic       valid_w [3], data_w [3], busy_w [3];
  logic [1:0] id_w [3];

  typedef struct { int inst; int idx; int gap; } gexp_t;
  typedef struct { int inst; int id; int data; } rexp_t;
  gexp_t gq[$];
  rexp_t rq[$];
  gexp_t mg;
  rexp_t mr;

  int         gcyc [3];
  logic       pvalid [3];
  logic [1:0] pid [3];
  logic       pdata [3];

  nt_subckt_eval_sched_if #(.NREQ(4), .DW(1)) b0 ();
  nt_subckt_eval_sched_if #(.NREQ(4), .DW(1)) b1 ();
  nt_subckt_eval_sched_if #(.NREQ(4), .DW(1)) b2 ();

  nt_subckt_eval_sched #(.NREQ(4), .DEPTH(3),  .DW(1)) u_dut0 (.I1470_clk(clk), .I1477_rst(rst_n), .bus(b0));
  nt_subckt_eval_sched #(.NREQ(4), .DEPTH(1),  .DW(1)) u_dut1 (.I1470_clk(clk), .I1477_rst(rst_n), .bus(b1));
  nt_subckt_eval_sched #(.NREQ(4), .DEPTH(15), .DW(1)) u_dut2 (.I1470_clk(clk), .I1477_rst(rst_n), .bus(b2));

  assign b0.req = req_s[0];  assign b1.req = req_s[1];  assign b2.req = req_s[2];
  assign b0.op_a = op_a_s;   assign b1.op_a = op_a_s;   assign b2.op_a = op_a_s;
  assign b0.op_b = op_b_s;   assign b1.op_b = op_b_s;   assign b2.op_b = op_b_s;
  assign b0.op_c = op_c_s;   assign b1.op_c = op_c_s;   assign b2.op_c = op_c_s;
  assign b0.resp_ready = rdy_s; assign b1.resp_ready = rdy_s; assign b2.resp_ready = rdy_s;
  assign b0.dp_q = pipe[0][2];
  assign b1.dp_q = pipe[1][0];
  assign b2.dp_q = pipe[2][14];

  assign grant_w[0] = b0.grant;      assign grant_w[1] = b1.grant;      assign grant_w[2] = b2.grant;
  assign en_w[0]    = b0.dp_en;      assign en_w[1]    = b1.dp_en;      assign en_w[2]    = b2.dp_en;
  assign dpa_w[0]   = b0.dp_a;       assign dpa_w[1]   = b1.dp_a;       assign dpa_w[2]   = b2.dp_a;
  assign dpb_w[0]   = b0.dp_b;       assign dpb_w[1]   = b1.dp_b;       assign dpb_w[2]   = b2.dp_b;
  assign dpc_w[0]   = b0.dp_c;       assign dpc_w[1]   = b1.dp_c;       assign dpc_w[2]   = b2.dp_c;
  assign valid_w[0] = b0.resp_valid; assign valid_w[1] = b1.resp_valid; assign valid_w[2] = b2.resp_valid;
  assign id_w[0]    = b0.resp_id;    assign id_w[1]    = b1.resp_id;    assign id_w[2]    = b2.resp_id;
  assign data_w[0]  = b0.resp_data; assign data_w[1]  = b1.resp_data;  assign data_w[2]  = b2.resp_data;
  assign busy_w[0]  = b0.busy;       assign busy_w[1]  = b1.busy;       assign busy_w[2]  = b2.busy;

  function automatic int dep_of(input int i);
    case (i)
      0: return 3;
      1: return 1;
      default: return 15;
    endcase
  endfunction

  // Subcircuit model: a&b&c taken on dp_en, delayed through a shift register
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 3; i++) pipe[i] <= 16'h0000;
    end else begin
      for (int i = 0; i < 3; i++)
        pipe[i] <= {pipe[i][14:0], en_w[i] & dpa_w[i] & dpb_w[i] & dpc_w[i]};
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pops expected grants/responses whenever a DUT presents one
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (grant_w[i] != 4'b0000) begin
        chk("grant_expected", int'(gq.size() > 0), 1);
        if (gq.size() > 0) begin
          mg = gq.pop_front();
          chk("grant_inst", i, mg.inst);
          chk("grant_onehot", int'(grant_w[i]), 1 << mg.idx);
          chk("dp_en", int'(en_w[i]), 1);
          chk("dp_ops", int'({dpa_w[i], dpb_w[i], dpc_w[i]}),
              int'({op_a_s[mg.idx], op_b_s[mg.idx], op_c_s[mg.idx]}));
          if (mg.gap != 0) chk("grant_gap", cyc - gcyc[i], mg.gap);
        end
        gcyc[i] = cyc;
      end
      if (valid_w[i] && !pvalid[i]) chk("grant_to_valid", cyc - gcyc[i], dep_of(i) + 1);
      if (valid_w[i] && pvalid[i]) begin
        chk("hold_id", int'(id_w[i]), int'(pid[i]));
        chk("hold_data", int'(data_w[i]), int'(pdata[i]));
      end
      if (valid_w[i] && rdy_s) begin
        chk("resp_expected", int'(rq.size() > 0), 1);
        if (rq.size() > 0) begin
          mr = rq.pop_front();
          chk("resp_inst", i, mr.inst);
          chk("resp_id", int'(id_w[i]), mr.id);
          chk("resp_data", int'(data_w[i]), mr.data);
        end
      end
      pvalid[i] = valid_w[i];
      pid[i]    = id_w[i];
      pdata[i]  = data_w[i];
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_grant(input int inst);
    int n;
    n = 0;
    do begin
      tick(1);
      n++;
    end while (grant_w[inst] == 4'b0000 && n < 200);
    chk("grant_timeout", int'(grant_w[inst] != 4'b0000), 1);
  endtask

  task automatic run_one(input int inst, input logic [3:0] mask, input logic [3:0] after,
                         input int idx, input int gap, input int r2g);
    gexp_t g;
    rexp_t r;
    int c0;
    g.inst = inst; g.idx = idx; g.gap = gap;
    r.inst = inst; r.id = idx; r.data = int'(op_a_s[idx] & op_b_s[idx] & op_c_s[idx]);
    gq.push_back(g);
    rq.push_back(r);
    req_s[inst] = mask;
    c0 = cyc;
    wait_grant(inst);
    if (r2g != 0) chk("req_to_grant", cyc - c0, 1);
    req_s[inst] = after;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((gq.size() != 0 || rq.size() != 0) && n < 300) begin
      tick(1);
      n++;
    end
    chk("drain", gq.size() + rq.size(), 0);
    tick(2);
  endtask

  task automatic check_reset(input int i);
    chk("rst_grant", int'(grant_w[i]), 0);
    chk("rst_ctrl", int'({en_w[i], valid_w[i], busy_w[i]}), 0);
    chk("rst_data", int'({dpa_w[i], dpb_w[i], dpc_w[i], data_w[i], id_w[i]}), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    gexp_t g;
    rexp_t r;
    rst_n = 1'b0;
    rdy_s = 1'b0;
    op_a_s = 4'b0000; op_b_s = 4'b0000; op_c_s = 4'b0000;
    for (int i = 0; i < 3; i++) begin
      req_s[i] = 4'b0000; gcyc[i] = 0; pvalid[i] = 1'b0; pid[i] = 2'd0; pdata[i] = 1'b0;
    end
    #2;
    for (int i = 0; i < 3; i++) check_reset(i);
    tick(2);
    rst_n = 1'b1;
    tick(2);

    // Single request from requester 1, operands (1,1,1)
    op_a_s = 4'b1011; op_b_s = 4'b0111; op_c_s = 4'b1110;
    rdy_s = 1'b1;
    run_one(0, 4'b0010, 4'b0000, 1, 0, 1);
    drain();

    // Reset two cycles after a grant to requester 2
    g.inst = 0; g.idx = 2; g.gap = 0;
    gq.push_back(g);
    req_s[0] = 4'b0100;
    wait_grant(0);
    req_s[0] = 4'b0000;
    tick(2);
    chk("wait_busy", int'(busy_w[0]), 1);
    rst_n = 1'b0;
    #1;
    check_reset(0);
    tick(1);
    rst_n = 1'b1;
    tick(1);

    // Round robin with all requests held; first grant proves ptr was cleared
    op_a_s = 4'b1111; op_b_s = 4'b1101; op_c_s = 4'b1011;
    for (int k = 0; k < 8; k++)
      run_one(0, 4'b1111, (k == 7) ? 4'b0000 : 4'b1111, k % 4, (k == 0) ? 0 : 6, (k == 0) ? 1 : 0);
    drain();

    // Backpressure: RESP held 10 cycles, no grant meanwhile
    rdy_s = 1'b0;
    run_one(0, 4'b1111, 4'b1111, 0, 0, 1);
    n_wait = 0;
    while (!valid_w[0] && n_wait < 50) begin
      tick(1);
      n_wait++;
    end
    chk("bp_valid", int'(valid_w[0]), 1);
    for (int k = 0; k < 10; k++) begin
      tick(1);
      chk("bp_nogrant", int'(grant_w[0]), 0);
    end
    g.inst = 0; g.idx = 1; g.gap = 0;
    r.inst = 0; r.id = 1; r.data = int'(op_a_s[1] & op_b_s[1] & op_c_s[1]);
    gq.push_back(g);
    rq.push_back(r);
    rdy_s = 1'b1;
    tick(1);
    chk("bp_idle", int'(busy_w[0]), 0);
    chk("bp_idle_grant", int'(grant_w[0]), 0);
    tick(1);
    chk("bp_next_grant", int'(grant_w[0]), 2);
    req_s[0] = 4'b0000;
    drain();

    // Wrap and skip: ptr to 3, then 0101 serves 0 then 2; withdrawn req[2] gets nothing
    run_one(0, 4'b0100, 4'b0000, 2, 0, 1);
    drain();
    run_one(0, 4'b0101, 4'b0100, 0, 0, 1);
    run_one(0, 4'b0100, 4'b0000, 2, 0, 0);
    drain();
    run_one(0, 4'b0101, 4'b0000, 0, 0, 1);
    drain();
    for (int k = 0; k < 6; k++) begin
      tick(1);
      chk("skip_nogrant", int'(grant_w[0]), 0);
    end
    run_one(0, 4'b1100, 4'b0000, 2, 0, 1);
    drain();

    // DEPTH boundaries
    op_a_s = 4'b1011; op_b_s = 4'b1001; op_c_s = 4'b1111;
    run_one(1, 4'b0001, 4'b0000, 0, 0, 1);
    drain();
    run_one(1, 4'b0010, 4'b0000, 1, 0, 1);
    drain();
    run_one(2, 4'b1000, 4'b0000, 3, 0, 1);
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/nt_subckt_eval_sched.md
# nt_subckt_eval_sched

Scheduler that shares one Nt-node evaluation subcircuit, a fixed-latency AND/DFF pipeline with three data inputs and one registered output, between up to NREQ trojan-detection requesters. It arbitrates round-robin, drives the granted requester's operands into the shared datapath for one cycle and waits the datapath's pipeline depth. It then captures the result and returns it with the requester's index over a valid/ready response port. One evaluation is in flight at a time; the block sits between the per-node monitors and the shared subcircuit instance.

## Interface
- NREQ, 4, number of requesters (2..16)
- DEPTH, 3, datapath latency in cycles from dp_en to valid dp_q (1..15)
- DW, 1, operand/result width per channel
- I1470_clk  in  1  single clock, rising edge
- I1477_rst  in  1  reset, asynchronous, active-low
- req  in  NREQ  per-requester evaluation request, level, held until grant
- op_a, op_b, op_c  in  NREQ*DW each  packed operands; slice k belongs to requester k
- grant  out  NREQ  one-hot, one-cycle pulse; the operands of the granted slice are taken that cycle
- dp_a, dp_b, dp_c  out  DW each  operands to the shared subcircuit
- dp_en  out  1  operand-valid strobe to the subcircuit
- dp_q  in  DW  subcircuit result
- resp_valid  out  1  result available
- resp_ready  in  1  consumer accepts the result
- resp_id  out  $clog2(NREQ)  index of the requester that owns the result
- resp_data  out  DW  captured dp_q
- busy  out  1  high in every state except IDLE

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE: if any req bit is set, the round-robin arbiter picks the first set bit at or after ptr (wrapping). The winner index is registered and the next state is ISSUE. If no req bit is set, the FSM stays in IDLE.
- ISSUE (1 cycle):
  - grant[k]=1 and dp_en=1.
  - dp_a/b/c = op_a/b/c slice k, taken combinationally from the inputs and also registered.
  - The wait counter loads DEPTH-1. Next state is WAIT.
- WAIT: the counter decrements each cycle. When the counter is 0, dp_q is captured into resp_data, resp_id is set to k, and the next state is RESP. This places the capture exactly DEPTH cycles after the ISSUE cycle.
- RESP:
  - resp_valid=1; resp_data and resp_id stay stable.
  - When resp_valid and resp_ready are both high, ptr=(k+1) mod NREQ and the next state is IDLE.
- A req bit dropped before its grant is ignored and does not count as a fairness slot. A req that stays high after its grant starts a new request once the FSM returns to IDLE.
- dp_a/b/c hold their last issued value outside ISSUE. dp_en is 0 outside ISSUE.
- Reset (I1477_rst=0, at any time including mid-WAIT or mid-RESP): state=IDLE, ptr=0, counter=0, and every output is 0. Reset is asynchronous assert and synchronous-safe deassert. Any in-flight result is discarded.

## Timing
- Request-to-grant: req sampled in IDLE at cycle t gives grant at t+1.
- Grant-to-result: resp_valid rises at t+1+DEPTH+1. With DEPTH=3 that is 4 cycles after grant.
- Minimum request period per evaluation: DEPTH+3 cycles when resp_ready is held high. That is IDLE, ISSUE, DEPTH WAIT cycles, and RESP.
- resp_ready is sampled only in RESP. If it is low, RESP holds indefinitely with stable outputs.
- Fairness: with all NREQ requests held, grants rotate 0,1,…,NREQ-1,0 with no requester starved.
- Reset values: grant=0, dp_en=0, dp_a/b/c=0, resp_valid=0, resp_id=0, resp_data=0, busy=0.

## Structure
- Package nt_sched_pkg:
  - state enum {IDLE, ISSUE, WAIT, RESP};
  - default constants for NREQ, DEPTH and DW;
  - the counter-width function $clog2(DEPTH+1).
- Sub-module nt_rr_arbiter:
  - parameter NREQ; inputs req and ptr; outputs one-hot gnt, idx and any.
  - Purely combinational; the scheduler owns the ptr register.
- Top-level: FSM, wait counter, operand mux, result/ID capture registers.

## Test plan
- Reset mid-WAIT: issue a request from requester 2 and assert I1477_rst=0 two cycles after the grant. All outputs read 0 immediately, and after release the next grant goes to requester 0.
- Single request: NREQ=4, DEPTH=3, req=4'b0010, op slice 1 = (1,1,1), dp_q model = a&b&c delayed 3 cycles. Required: grant=4'b0010 at cycle 1, dp_en at cycle 1, resp_valid at cycle 5 with resp_id=1 and resp_data=1.
- Round-robin: hold req=4'b1111 with resp_ready=1. The grant sequence over 8 evaluations is 0,1,2,3,0,1,2,3, with one grant every 6 cycles.
- Backpressure: hold resp_ready=0 for 10 cycles in RESP. resp_valid, resp_id and resp_data stay stable, and no new grant occurs while req=4'b1111. One cycle after resp_ready=1 the FSM is in IDLE, and the next grant follows one cycle later.
- Wrap and skip: ptr=3 and req=4'b0101 gives a grant to 0, then a grant to 2. Withdrawing req[2] before its turn yields no grant to 2.
- DEPTH boundary: DEPTH=1 gives resp_valid 2 cycles after grant with the correct dp_q. DEPTH=15 gives 16 cycles.
